// File: rtl/seq_register_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters with a RUN/STALL/DRAIN issue gate.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a source whose final pending write lands this cycle is forwarded, not stalled.
module seq_register_scoreboard #(
  parameter int REG_COUNT = 8,
  parameter int CNT_WIDTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  input  logic        i_issue_has_dest,
  input  logic [2:0]  i_issue_dest,
  input  logic        i_src1_valid,
  input  logic        i_src2_valid,
  input  logic [2:0]  i_src1,
  input  logic [2:0]  i_src2,
  input  logic        i_wb_valid,
  input  logic [2:0]  i_wb_dest,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_error,
  output logic [15:0] o_stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] pending_reg  [REG_COUNT];
  logic [CNT_WIDTH-1:0] pending_next [REG_COUNT];
  logic [REG_COUNT-1:0] zero_next;
  logic                 error_reg;
  logic [15:0]          stall_cycles_reg;

  logic src1_fwd, src2_fwd;
  logic src1_hazard, src2_hazard, dest_hazard;
  logic hazard, issue_hazard, accept, wb_orphan;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign src1_fwd = i_wb_valid && (i_wb_dest == i_src1) && (pending_reg[i_src1] == CNT_ONE);
  assign src2_fwd = i_wb_valid && (i_wb_dest == i_src2) && (pending_reg[i_src2] == CNT_ONE);
`else
  assign src1_fwd = 1'b0;
  assign src2_fwd = 1'b0;
`endif

  assign src1_hazard  = i_src1_valid && (pending_reg[i_src1] != '0) && !src1_fwd;
  assign src2_hazard  = i_src2_valid && (pending_reg[i_src2] != '0) && !src2_fwd;
  // A saturated counter cannot absorb another outstanding write.
  assign dest_hazard  = i_issue_has_dest && (pending_reg[i_issue_dest] == CNT_MAX);
  assign hazard       = src1_hazard || src2_hazard || dest_hazard;
  assign issue_hazard = i_issue_valid && hazard;

  assign o_stall = (state_reg == DRAIN) || issue_hazard;
  assign accept  = i_issue_valid && !o_stall && !i_flush;
  assign wb_orphan = i_wb_valid && (pending_reg[i_wb_dest] == '0);

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_cnt
      logic inc, dec;
      assign inc = accept && i_issue_has_dest && (i_issue_dest == 3'(gi));
      assign dec = i_wb_valid && (i_wb_dest == 3'(gi)) && (pending_reg[gi] != '0);
      // Simultaneous issue and writeback to the same register cancel out.
      assign pending_next[gi] = (inc && !dec) ? pending_reg[gi] + CNT_ONE :
                                (dec && !inc) ? pending_reg[gi] - CNT_ONE :
                                                pending_reg[gi];
      assign zero_next[gi] = (pending_next[gi] == '0);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg        <= RUN;
      error_reg        <= 1'b0;
      stall_cycles_reg <= '0;
      for (int r = 0; r < REG_COUNT; r++) pending_reg[r] <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) pending_reg[r] <= pending_next[r];
      if (wb_orphan) error_reg <= 1'b1;
      if ((state_reg != DRAIN) && o_stall && (stall_cycles_reg != 16'hFFFF))
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      case (state_reg)
        RUN: begin
          if (i_flush)           state_reg <= DRAIN;
          else if (issue_hazard) state_reg <= STALL;
        end
        STALL: begin
          if (i_flush)            state_reg <= DRAIN;
          else if (!issue_hazard) state_reg <= RUN;
        end
        // Leave once every in-flight write has landed, counting this edge's writeback.
        DRAIN: begin
          if (&zero_next) state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign o_busy         = (state_reg == DRAIN);
  assign o_error        = error_reg;
  assign o_stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_seq_register_scoreboard.sv
// Directed bench for seq_register_scoreboard: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_seq_register_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_has_dest;
  logic [2:0]  issue_dest;
  logic        src1_valid, src2_valid;
  logic [2:0]  src1, src2;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic        flush;
  logic        stall, busy, error;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  seq_register_scoreboard dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_issue_valid    (issue_valid),
    .i_issue_has_dest (issue_has_dest),
    .i_issue_dest     (issue_dest),
    .i_src1_valid     (src1_valid),
    .i_src2_valid     (src2_valid),
    .i_src1           (src1),
    .i_src2           (src2),
    .i_wb_valid       (wb_valid),
    .i_wb_dest        (wb_dest),
    .i_flush          (flush),
    .o_stall          (stall),
    .o_busy           (busy),
    .o_error          (error),
    .o_stall_cycles   (stall_cycles)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic        err_exp = 1'b0;
  logic [15:0] cyc_exp = 16'd0;
  bit          stall_pending = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (stall !== cur.stall || busy !== cur.busy || error !== cur.err || stall_cycles !== cur.cyc) begin
        errors++;
        $display("FAIL %s: got stall=%0b busy=%0b error=%0b stall_cycles=%h, expected stall=%0b busy=%0b error=%0b stall_cycles=%h",
                 cur.name, stall, busy, error, stall_cycles, cur.stall, cur.busy, cur.err, cur.cyc);
      end else begin
        $display("ok   %s: stall=%0b busy=%0b error=%0b stall_cycles=%h",
                 cur.name, stall, busy, error, stall_cycles);
      end
    end
  end

  task automatic idle();
    issue_valid = 0; issue_has_dest = 0; issue_dest = 0;
    src1_valid = 0; src2_valid = 0; src1 = 0; src2 = 0;
    wb_valid = 0; wb_dest = 0; flush = 0;
  endtask

  task automatic expect_out(input string name, input logic st, input logic bz);
    exp_t e;
    e.name = name; e.stall = st; e.busy = bz; e.err = err_exp; e.cyc = cyc_exp;
    exp_q.push_back(e);
    stall_pending = st && !bz;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (stall_pending && cyc_exp != 16'hFFFF) cyc_exp = cyc_exp + 16'd1;
    stall_pending = 1'b0;
  endtask

  task automatic issue_dest_only(input logic [2:0] d);
    idle(); issue_valid = 1; issue_has_dest = 1; issue_dest = d;
  endtask

  initial begin
    idle(); rst = 1;
    tick(); tick();
    rst = 0;
    expect_out("reset", 0, 0); tick();

    // RAW hazard on r3
    issue_dest_only(3'd3); expect_out("issue_d3", 0, 0); tick();
    idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd3;
    expect_out("raw_r3_stall", 1, 0); tick();
    wb_valid = 1; wb_dest = 3'd3;
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_out("raw_r3_wb_fwd", 0, 0); tick();
`else
    expect_out("raw_r3_wb", 1, 0); tick();
`endif
    wb_valid = 0; expect_out("raw_r3_clear", 0, 0); tick();

    // Counter saturation on r5
    issue_dest_only(3'd5);
    for (int i = 0; i < 3; i++) begin
      expect_out("issue_d5", 0, 0); tick();
    end
    expect_out("d5_full_stall", 1, 0); tick();
    wb_valid = 1; wb_dest = 3'd5; expect_out("d5_full_wb", 1, 0); tick();
    wb_valid = 0; expect_out("d5_accept", 0, 0); tick();
    expect_out("d5_full_again", 1, 0); tick();
    idle(); wb_valid = 1; wb_dest = 3'd5;
    for (int i = 0; i < 3; i++) begin
      expect_out("wb_r5", 0, 0); tick();
    end
    idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd5;
    expect_out("r5_drained", 0, 0); tick();

    // Same-cycle issue and writeback on r2
    issue_dest_only(3'd2); expect_out("issue_d2", 0, 0); tick();
    wb_valid = 1; wb_dest = 3'd2; expect_out("d2_issue_wb", 0, 0); tick();
    idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd2;
    expect_out("r2_still_one", 1, 0); tick();
    idle(); wb_valid = 1; wb_dest = 3'd2; expect_out("wb_r2", 0, 0); tick();
    idle(); issue_valid = 1; src2_valid = 1; src2 = 3'd2;
    expect_out("r2_zero", 0, 0); tick();

    // Orphan writeback on r7 sets the sticky error
    idle(); wb_valid = 1; wb_dest = 3'd7; expect_out("wb_r7_orphan", 0, 0); tick();
    err_exp = 1'b1;
    idle(); expect_out("error_set", 0, 0); tick();
    expect_out("error_sticky", 0, 0); tick();

    // Flush and drain with r1, r4 in flight
    issue_dest_only(3'd1); expect_out("issue_d1", 0, 0); tick();
    issue_dest_only(3'd4); expect_out("issue_d4", 0, 0); tick();
    issue_dest_only(3'd6); flush = 1; expect_out("flush", 0, 0); tick();
    flush = 0; expect_out("drain_ignore_issue", 1, 1); tick();
    idle(); wb_valid = 1; wb_dest = 3'd1; flush = 1;
    expect_out("drain_wb_r1", 1, 1); tick();
    flush = 0; wb_dest = 3'd4; expect_out("drain_wb_r4", 1, 1); tick();
    idle(); expect_out("drain_done", 0, 0); tick();
    idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd6;
    expect_out("r6_not_issued", 0, 0); tick();
    idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd1; src2_valid = 1; src2 = 3'd4;
    expect_out("r1_r4_clear", 0, 0); tick();

    // Long hazard saturates the stall counter, then reset mid-stall
    issue_dest_only(3'd0); expect_out("issue_d0", 0, 0); tick();
    idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd0;
    expect_out("hold_start", 1, 0); tick();
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
      if (cyc_exp != 16'hFFFF) cyc_exp = cyc_exp + 16'd1;
    end
    expect_out("stall_saturated", 1, 0); tick();
    rst = 1; tick();
    cyc_exp = 16'd0; err_exp = 1'b0;
    expect_out("in_reset", 0, 0); tick();
    rst = 0; expect_out("post_reset_no_pending", 0, 0); tick();

    // Reset abandons a drain
    issue_dest_only(3'd4); expect_out("issue_d4_again", 0, 0); tick();
    idle(); flush = 1; expect_out("flush_again", 0, 0); tick();
    flush = 0; expect_out("drain_again", 1, 1); tick();
    rst = 1; tick();
    rst = 0; idle(); issue_valid = 1; src1_valid = 1; src1 = 3'd4;
    expect_out("reset_in_drain", 0, 0); tick();

    idle();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL monitor_timeout: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
